// File: rtl/bg_pkg.sv
// Shared definitions for the background/obstacle layer: gameState encodings,
// scroll scheduler states, ground width default and LFSR constants.
package bg_pkg;

   localparam logic [1:0] GS_START   = 2'd0;
   localparam logic [1:0] GS_RUNNING = 2'd1;
   localparam logic [1:0] GS_OVER    = 2'd2;

   typedef enum logic [1:0] {
      SS_IDLE = 2'd0,
      SS_RUN  = 2'd1,
      SS_STOP = 2'd2
   } sched_state_e;

   localparam int unsigned GROUND_W_DEFAULT = 1200;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Reserved encoding 3 behaves like OVER.
   function automatic sched_state_e decode_state(input logic [1:0] gs);
      case (gs)
         GS_START:   return SS_IDLE;
         GS_RUNNING: return SS_RUN;
         default:    return SS_STOP;
      endcase
   endfunction

endpackage

// File: rtl/scroll_scheduler_lfsr16.sv
// 16-bit Galois LFSR, one step per frame; feeds spawn seeds and spawn gaps.
module lfsr16
   import bg_pkg::*;
(
   input  logic        FrameClk,
   input  logic        rst_n,
   output logic [15:0] out
);

   always_ff @(posedge FrameClk or negedge rst_n) begin
      if (!rst_n)
         out <= LFSR_SEED;
      else
         out <= out[0] ? ((out >> 1) ^ LFSR_TAPS) : (out >> 1);
   end

endmodule

// File: rtl/scroll_scheduler.sv
// Per-frame scroll controller: ground offset, dx ramp, distance and spawn handshake.
// Optional build macro SCROLL_PAUSE_EN adds a `pause` input that freezes RUN progress.
module scroll_scheduler
   import bg_pkg::*;
#(
   parameter int unsigned GROUND_W    = GROUND_W_DEFAULT,
   parameter int unsigned DX_INIT     = 6,
   parameter int unsigned DX_MAX      = 16,
   parameter int unsigned RAMP_FRAMES = 300,
   parameter int unsigned SPAWN_MIN   = 40,
   parameter int unsigned SPAWN_SPAN  = 64
) (
   input  logic        FrameClk,
   input  logic        rst_n,
   input  logic [1:0]  gameState,
   input  logic        spawnAck,
`ifdef SCROLL_PAUSE_EN
   input  logic        pause,
`endif
   output logic [31:0] groundX,
   output logic [7:0]  dx,
   output logic [31:0] distance,
   output logic        spawnReq,
   output logic [7:0]  spawnSeed
);

   localparam logic [32:0] GW        = 33'(GROUND_W);
   localparam logic [7:0]  DXI       = 8'(DX_INIT);
   localparam logic [7:0]  DXM       = 8'(DX_MAX);
   localparam logic [31:0] RAMP_LAST = 32'(RAMP_FRAMES - 1);
   localparam logic [15:0] SMIN      = 16'(SPAWN_MIN);
   localparam logic [15:0] SMASK     = 16'(SPAWN_SPAN - 1);

   sched_state_e state, next_state;
   logic [31:0]  ramp_cnt;
   logic [15:0]  spawn_cnt;
   logic [15:0]  lfsr;
   logic         hold;
   logic [32:0]  g_sum, g_diff, d_sum;
   logic [31:0]  g_next, d_next;
   logic [7:0]   dx_next;

   lfsr16 u_lfsr (
      .FrameClk (FrameClk),
      .rst_n    (rst_n),
      .out      (lfsr)
   );

`ifdef SCROLL_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   assign next_state = decode_state(gameState);

   always_comb begin
      g_sum   = {1'b0, groundX} + {25'd0, dx};
      g_diff  = g_sum - GW;
      g_next  = (g_sum >= GW) ? g_diff[31:0] : g_sum[31:0];
      d_sum   = {1'b0, distance} + {25'd0, dx};
      d_next  = d_sum[32] ? '1 : d_sum[31:0];
      dx_next = (dx >= DXM) ? DXM : dx + 8'd1;
   end

   always_ff @(posedge FrameClk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SS_IDLE;
         groundX   <= '0;
         dx        <= DXI;
         distance  <= '0;
         spawnReq  <= 1'b0;
         spawnSeed <= '0;
         ramp_cnt  <= '0;
         spawn_cnt <= SMIN;
      end else begin
         state <= next_state;
         case (next_state)
            SS_RUN: begin
               if (state != SS_RUN) begin
                  groundX   <= '0;
                  dx        <= DXI;
                  distance  <= '0;
                  ramp_cnt  <= '0;
                  spawn_cnt <= SMIN;
                  spawnReq  <= 1'b0;
               end else begin
                  if (!hold) begin
                     groundX  <= g_next;
                     distance <= d_next;
                     if (ramp_cnt == RAMP_LAST) begin
                        ramp_cnt <= '0;
                        dx       <= dx_next;
                     end else begin
                        ramp_cnt <= ramp_cnt + 32'd1;
                     end
                  end
                  // Ack is honoured even while paused; the countdown only runs unpaused.
                  if (spawnReq) begin
                     if (spawnAck) begin
                        spawnReq  <= 1'b0;
                        spawn_cnt <= SMIN + (lfsr & SMASK);
                     end
                  end else if (!hold) begin
                     if (spawn_cnt == '0) begin
                        spawnReq  <= 1'b1;
                        spawnSeed <= lfsr[7:0];
                     end else begin
                        spawn_cnt <= spawn_cnt - 16'd1;
                     end
                  end
               end
            end
            SS_STOP: begin
               spawnReq <= 1'b0;
            end
            default: begin
               dx       <= DXI;
               spawnReq <= 1'b0;
            end
         endcase
      end
   end

endmodule
